seg7_scan_decoder: RTL and testbench

Receive side of the multiplexed active-low 7-segment display interface. The block samples the shared segment bus {a,b,c,d,e,f,g} together with the active-low one-hot digit-select lines. It waits for each digit's pattern to settle, decodes it back to a 4-bit hex nibble, and assembles a full multi-digit frame. It sits on the test/loopback path behind the display driver, so display output can be checked in-system and in simulation.

---
 rtl/seg7_scan_decoder.sv | 186 ++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Loopback receiver for a multiplexed active-low 7-segment display: debounces each digit, decodes it to hex, assembles frames.
// Optional blank-pattern support is enabled with `define SEG7_BLANK_DETECT_EN (adds the blank_out port).
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic                    busy
`ifdef SEG7_BLANK_DETECT_EN
  , output logic [NUM_DIGITS-1:0] blank_out
`endif
);

  localparam int         IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] STABLE_M1 = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  state_t                  state_q;
  logic [6:0]              seg_q, seg_p;
  logic [NUM_DIGITS-1:0]   an_q, an_p;
  logic [7:0]              cnt_q;
  logic [NUM_DIGITS-1:0]   mask_q;
  logic [4*NUM_DIGITS-1:0] stage_hex_q, hex_q;
  logic [NUM_DIGITS-1:0]   stage_err_q, err_q;
  logic                    fv_q;
  logic [IW-1:0]           cap_idx_q;
  logic [3:0]              cap_nib_q;
  logic                    cap_err_q;
  logic [NUM_DIGITS-1:0]   cap_an_q;

  logic [3:0]              dec_nib;
  logic                    dec_err;
  logic                    dec_blank;
  logic                    an_valid;
  logic [IW-1:0]           an_idx;

  always_comb begin
    dec_nib   = 4'h0;
    dec_err   = 1'b0;
    dec_blank = 1'b0;
    case (seg_q)
      7'b0000001: dec_nib = 4'h0;
      7'b1001111: dec_nib = 4'h1;
      7'b0010010: dec_nib = 4'h2;
      7'b0000110: dec_nib = 4'h3;
      7'b1001100: dec_nib = 4'h4;
      7'b0100100: dec_nib = 4'h5;
      7'b0100000: dec_nib = 4'h6;
      7'b0001111: dec_nib = 4'h7;
      7'b0000000: dec_nib = 4'h8;
      7'b0000100: dec_nib = 4'h9;
      7'b0001000: dec_nib = 4'hA;
      7'b1100000: dec_nib = 4'hB;
      7'b0110001: dec_nib = 4'hC;
      7'b1000010: dec_nib = 4'hD;
      7'b0110000: dec_nib = 4'hE;
      7'b0111000: dec_nib = 4'hF;
`ifdef SEG7_BLANK_DETECT_EN
      7'b1111111: dec_blank = 1'b1;
`endif
      default:    dec_err = 1'b1;
    endcase
  end

  always_comb begin
    an_valid = ($countones(~an_q) == 1);
    an_idx   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i]) an_idx = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= 7'h7F;
      seg_p <= 7'h7F;
      an_q  <= '1;
      an_p  <= '1;
    end else begin
      seg_q <= seg;
      seg_p <= seg_q;
      an_q  <= an;
      an_p  <= an_q;
    end
  end

`ifdef SEG7_BLANK_DETECT_EN
  logic                  cap_blank_q;
  logic [NUM_DIGITS-1:0] stage_blank_q, blank_q;
  assign blank_out = blank_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_blank_q   <= 1'b0;
      stage_blank_q <= '0;
      blank_q       <= '0;
    end else begin
      if (mask_q == '1) blank_q <= stage_blank_q;
      if (state_q == SETTLE) cap_blank_q <= dec_blank;
      if (state_q == CAPTURE) stage_blank_q[cap_idx_q] <= cap_blank_q;
    end
  end
`else
  logic unused_blank;
  assign unused_blank = dec_blank;
`endif

  // A simultaneous seg/an change is seen as an an change because an validity decides the SETTLE restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mask_q      <= '0;
      stage_hex_q <= '0;
      stage_err_q <= '0;
      hex_q       <= '0;
      err_q       <= '0;
      fv_q        <= 1'b0;
      cap_idx_q   <= '0;
      cap_nib_q   <= '0;
      cap_err_q   <= 1'b0;
      cap_an_q    <= '1;
    end else begin
      fv_q <= 1'b0;
      if (mask_q == '1) begin
        hex_q  <= stage_hex_q;
        err_q  <= stage_err_q;
        fv_q   <= 1'b1;
        mask_q <= '0;
      end
      case (state_q)
        IDLE: begin
          if (an_valid) begin
            state_q <= SETTLE;
            cnt_q   <= 8'd1;
          end
        end
        SETTLE: begin
          if ((an_q != an_p) || (seg_q != seg_p)) begin
            if (an_valid) cnt_q <= 8'd1;
            else          state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q >= STABLE_M1) begin
              state_q   <= CAPTURE;
              cap_idx_q <= an_idx;
              cap_nib_q <= dec_nib;
              cap_err_q <= dec_err;
              cap_an_q  <= an_q;
            end
          end
        end
        CAPTURE: begin
          stage_hex_q[4*cap_idx_q +: 4] <= cap_nib_q;
          stage_err_q[cap_idx_q]        <= cap_err_q;
          mask_q[cap_idx_q]             <= 1'b1;
          state_q                       <= HOLD;
        end
        HOLD: begin
          if (an_q != cap_an_q) begin
            if (an_valid) begin
              state_q <= SETTLE;
              cnt_q   <= 8'd1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hex_out     = hex_q;
  assign digit_err   = err_q;
  assign frame_valid = fv_q;
  assign busy        = (mask_q != '0);

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=4); build with SEG7_BLANK_DETECT_EN to cover blank_out.
module tb_seg7_scan_decoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  an = 4'hF;
  logic [15:0] hex_out;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        busy;
`ifdef SEG7_BLANK_DETECT_EN
  logic [3:0]  blank_out;
  logic [3:0]  fv_blank;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int fv_total = 0;
  int fv_run = 0;
  int fv_maxrun = 0;
  logic [15:0] fv_hex = '0;
  logic [3:0]  fv_err = '0;

  seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an),
    .hex_out(hex_out), .digit_err(digit_err), .frame_valid(frame_valid), .busy(busy)
`ifdef SEG7_BLANK_DETECT_EN
    , .blank_out(blank_out)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_total++;
      fv_run++;
      if (fv_run > fv_maxrun) fv_maxrun = fv_run;
      fv_hex = hex_out;
      fv_err = digit_err;
`ifdef SEG7_BLANK_DETECT_EN
      fv_blank = blank_out;
`endif
    end else begin
      fv_run = 0;
    end
  end

  task automatic show(input int d, input logic [6:0] s, input int n);
    an  = ~(4'b0001 << d);
    seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    an  = 4'hF;
    seg = 7'h7F;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    n_checks++; if (hex_out !== 16'h0) begin n_fail++; $display("FAIL reset_hex got %h want 0000", hex_out); end
    n_checks++; if (digit_err !== 4'h0) begin n_fail++; $display("FAIL reset_err got %b want 0000", digit_err); end
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv got %b want 0", frame_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
`ifdef SEG7_BLANK_DETECT_EN
    n_checks++; if (blank_out !== 4'h0) begin n_fail++; $display("FAIL reset_blank got %b want 0000", blank_out); end
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic_frame;
    int base;
    base = fv_total;
    show(0, 7'h4F, 6);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_mid got %b want 1", busy); end
    show(1, 7'h12, 6);
    show(2, 7'h06, 6);
    show(3, 7'h4C, 6);
    idle(4);
    n_checks++; if (fv_total - base !== 1) begin n_fail++; $display("FAIL basic_fv_count got %0d want 1", fv_total - base); end
    n_checks++; if (fv_hex !== 16'h4321) begin n_fail++; $display("FAIL basic_hex got %h want 4321", fv_hex); end
    n_checks++; if (fv_err !== 4'h0) begin n_fail++; $display("FAIL basic_err got %b want 0000", fv_err); end
    n_checks++; if (fv_maxrun !== 1) begin n_fail++; $display("FAIL basic_fv_width got %0d want 1", fv_maxrun); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got %b want 0", busy); end
  endtask

  task automatic test_glitch;
    int base;
    base = fv_total;
    show(0, 7'h12, 2);
    show(0, 7'h06, 6);
    show(1, 7'h24, 6);
    show(2, 7'h20, 6);
    show(3, 7'h0F, 6);
    idle(4);
    n_checks++; if (fv_total - base !== 1) begin n_fail++; $display("FAIL glitch_fv_count got %0d want 1", fv_total - base); end
    n_checks++; if (fv_hex !== 16'h7653) begin n_fail++; $display("FAIL glitch_hex got %h want 7653", fv_hex); end
  endtask

  task automatic test_illegal;
    show(0, 7'h01, 6);
    show(1, 7'h42, 6);
    show(2, 7'h55, 6);
    show(3, 7'h38, 6);
    idle(4);
    n_checks++; if (fv_hex !== 16'hF0D0) begin n_fail++; $display("FAIL illegal_hex got %h want f0d0", fv_hex); end
    n_checks++; if (fv_err !== 4'b0100) begin n_fail++; $display("FAIL illegal_err got %b want 0100", fv_err); end
  endtask

  task automatic test_recapture;
    int base;
    base = fv_total;
    show(0, 7'h4F, 6);
    show(1, 7'h12, 6);
    show(0, 7'h30, 6);
    n_checks++; if (fv_total - base !== 0) begin n_fail++; $display("FAIL recap_early_fv got %0d want 0", fv_total - base); end
    show(2, 7'h00, 6);
    show(3, 7'h04, 6);
    idle(4);
    n_checks++; if (fv_total - base !== 1) begin n_fail++; $display("FAIL recap_fv_count got %0d want 1", fv_total - base); end
    n_checks++; if (fv_hex !== 16'h982E) begin n_fail++; $display("FAIL recap_hex got %h want 982e", fv_hex); end
    n_checks++; if (fv_err !== 4'h0) begin n_fail++; $display("FAIL recap_err got %b want 0000", fv_err); end
  endtask

  task automatic test_multi_select;
    int base;
    base = fv_total;
    show(0, 7'h24, 6);
    an  = 4'b1100;
    seg = 7'h00;
    repeat (10) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL multi_busy got %b want 1", busy); end
    n_checks++; if (fv_total - base !== 0) begin n_fail++; $display("FAIL multi_fv got %0d want 0", fv_total - base); end
    show(1, 7'h20, 6);
    show(2, 7'h0F, 6);
    show(3, 7'h00, 6);
    idle(4);
    n_checks++; if (fv_hex !== 16'h8765) begin n_fail++; $display("FAIL multi_hex got %h want 8765", fv_hex); end
  endtask

  task automatic test_reset_mid_frame;
    int base;
    base = fv_total;
    show(0, 7'h4F, 6);
    show(1, 7'h12, 6);
    show(2, 7'h04, 2);
    rst_n = 1'b0;
    #1;
    n_checks++; if (hex_out !== 16'h0) begin n_fail++; $display("FAIL midrst_hex got %h want 0000", hex_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_checks++; if (digit_err !== 4'h0) begin n_fail++; $display("FAIL midrst_err got %b want 0000", digit_err); end
    an  = 4'hF;
    seg = 7'h7F;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    show(2, 7'h04, 6);
    show(3, 7'h08, 6);
    idle(4);
    n_checks++; if (fv_total - base !== 0) begin n_fail++; $display("FAIL midrst_no_frame got %0d want 0", fv_total - base); end
    show(0, 7'h60, 6);
    show(1, 7'h31, 6);
    idle(4);
    n_checks++; if (fv_total - base !== 1) begin n_fail++; $display("FAIL midrst_fv_count got %0d want 1", fv_total - base); end
    n_checks++; if (fv_hex !== 16'hA9CB) begin n_fail++; $display("FAIL midrst_hex_frame got %h want a9cb", fv_hex); end
  endtask

  task automatic test_blank;
    show(0, 7'h4F, 6);
    show(1, 7'h12, 6);
    show(2, 7'h06, 6);
    show(3, 7'h7F, 6);
    idle(4);
    n_checks++; if (fv_hex !== 16'h0321) begin n_fail++; $display("FAIL blank_hex got %h want 0321", fv_hex); end
`ifdef SEG7_BLANK_DETECT_EN
    n_checks++; if (fv_err !== 4'h0) begin n_fail++; $display("FAIL blank_err got %b want 0000", fv_err); end
    n_checks++; if (fv_blank !== 4'b1000) begin n_fail++; $display("FAIL blank_flag got %b want 1000", fv_blank); end
`else
    n_checks++; if (fv_err !== 4'b1000) begin n_fail++; $display("FAIL blank_err got %b want 1000", fv_err); end
`endif
  endtask

  task automatic test_back_to_back;
    int base;
    base = fv_total;
    show(0, 7'h08, 6);
    show(1, 7'h60, 6);
    show(2, 7'h31, 6);
    show(3, 7'h42, 6);
    show(0, 7'h01, 6);
    show(1, 7'h01, 6);
    show(2, 7'h38, 6);
    idle(2);
    n_checks++; if (fv_total - base !== 1) begin n_fail++; $display("FAIL b2b_first_count got %0d want 1", fv_total - base); end
    n_checks++; if (fv_hex !== 16'hDCBA) begin n_fail++; $display("FAIL b2b_first_hex got %h want dcba", fv_hex); end
    n_checks++; if (fv_err !== 4'h0) begin n_fail++; $display("FAIL b2b_first_err got %b want 0000", fv_err); end
`ifdef SEG7_BLANK_DETECT_EN
    n_checks++; if (fv_blank !== 4'h0) begin n_fail++; $display("FAIL b2b_blank got %b want 0000", fv_blank); end
`endif
    show(3, 7'h4F, 6);
    idle(4);
    n_checks++; if (fv_total - base !== 2) begin n_fail++; $display("FAIL b2b_second_count got %0d want 2", fv_total - base); end
    n_checks++; if (fv_hex !== 16'h1F00) begin n_fail++; $display("FAIL b2b_second_hex got %h want 1f00", fv_hex); end
    n_checks++; if (fv_maxrun !== 1) begin n_fail++; $display("FAIL fv_width got %0d want 1", fv_maxrun); end
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_glitch;
    test_illegal;
    test_recapture;
    test_multi_select;
    test_reset_mid_frame;
    test_blank;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
